// File: rtl/tinyqv_multi_mem_seq.sv
`default_nettype none
// ============================================================================
// Module   : tinyqv_multi_mem_seq
// Purpose  : Multi-word memory op sequencer (LW2/LW4, SW2/SW4, memset, LCXT/SCXT).
//            Accepts one burst command and issues num_extra+1 word accesses to
//            consecutive addresses, stepping the register index per access.
// Revision : 1.0 - initial release
// ============================================================================
module tinyqv_multi_mem_seq #(
   parameter int REG_ADDR_BITS = 4,
   parameter int ADDR_BITS     = 28
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     start_ready,
   input  logic [ADDR_BITS-1:0]     base_addr,
   input  logic [REG_ADDR_BITS-1:0] first_reg,
   input  logic [2:0]               num_extra,
   input  logic                     is_store,
   input  logic                     inc_reg,
   input  logic                     flush,
   output logic                     mem_req,
   input  logic                     mem_ack,
   output logic [ADDR_BITS-1:0]     mem_addr,
   output logic                     mem_write,
   output logic [31:0]              mem_wdata,
   input  logic [31:0]              mem_rdata,
   output logic [REG_ADDR_BITS-1:0] rs_addr,
   input  logic [31:0]              rs_data,
   output logic                     rd_wen,
   output logic [REG_ADDR_BITS-1:0] rd_addr,
   output logic [31:0]              rd_data,
   output logic                     busy,
   output logic                     done
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [ADDR_BITS-1:0]     C_WORD_STEP = ADDR_BITS'(4);
   localparam logic [REG_ADDR_BITS-1:0] C_REG_ZERO  = '0;

   logic [1:0]               state_q,     state_d;
   logic [ADDR_BITS-1:0]     addr_q,      addr_d;
   logic [REG_ADDR_BITS-1:0] reg_q,       reg_d;
   logic [2:0]               remaining_q, remaining_d;
   logic                     store_q,     store_d;
   logic                     inc_q,       inc_d;

   // Next-state: latch a command in IDLE, step address/register on each ack,
   // abort on flush (a same-cycle ack is still visible through rd_wen).
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      reg_d       = reg_q;
      remaining_d = remaining_q;
      store_d     = store_q;
      inc_d       = inc_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               addr_d      = base_addr;
               reg_d       = first_reg;
               remaining_d = num_extra;
               store_d     = is_store;
               inc_d       = inc_reg;
               state_d     = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (mem_ack) begin
               if (remaining_q != 3'd0) begin
                  addr_d      = addr_q + C_WORD_STEP;
                  reg_d       = reg_q + {C_REG_ZERO[REG_ADDR_BITS-1:1], inc_q};
                  remaining_d = remaining_q - 3'd1;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and burst context registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         reg_q       <= '0;
         remaining_q <= 3'd0;
         store_q     <= 1'b0;
         inc_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         reg_q       <= reg_d;
         remaining_q <= remaining_d;
         store_q     <= store_d;
         inc_q       <= inc_d;
      end
   end

   assign start_ready = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign mem_req     = (state_q == ST_ACTIVE);
   assign mem_addr    = addr_q;
   assign mem_write   = store_q;
   assign mem_wdata   = rs_data;
   assign rs_addr     = reg_q;
   assign rd_addr     = reg_q;
   assign rd_data     = mem_rdata;
   assign rd_wen      = mem_ack & mem_req & ~mem_write & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_tinyqv_multi_mem_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tinyqv_multi_mem_seq
// Purpose  : Self-checking bench for the multi-word memory op sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tinyqv_multi_mem_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [27:0] base_addr = '0;
   logic [3:0]  first_reg = '0;
   logic [2:0]  num_extra = '0;
   logic        is_store = 1'b0;
   logic        inc_reg = 1'b0;
   logic        flush = 1'b0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] rs_data = '0;
   logic        start_ready, mem_req, mem_write, rd_wen, busy, done;
   logic [27:0] mem_addr;
   logic [31:0] mem_wdata, rd_data;
   logic [3:0]  rs_addr, rd_addr;

   tinyqv_multi_mem_seq #(.REG_ADDR_BITS(4), .ADDR_BITS(28)) dut (
      .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
      .base_addr(base_addr), .first_reg(first_reg), .num_extra(num_extra),
      .is_store(is_store), .inc_reg(inc_reg), .flush(flush),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
      .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .rs_addr(rs_addr), .rs_data(rs_data), .rd_wen(rd_wen),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit en_cmp = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: list of outstanding accesses ----------
   typedef struct {
      logic [27:0] a;
      logic [3:0]  r;
      logic        w;
   } acc_t;
   acc_t mq[$];
   bit   m_done = 1'b0;

   always @(posedge clk or posedge rst) begin : model
      bit was_idle;
      acc_t e;
      if (rst) begin
         mq.delete();
         m_done = 1'b0;
      end else begin
         was_idle = (mq.size() == 0) && !m_done;
         if (m_done) m_done = 1'b0;
         else if (mq.size() != 0) begin
            if (flush) mq.delete();
            else if (mem_ack) begin
               void'(mq.pop_front());
               if (mq.size() == 0) m_done = 1'b1;
            end
         end
         if (was_idle && start && !flush) begin
            for (int i = 0; i <= int'(num_extra); i++) begin
               e.a = base_addr + 28'(4 * i);
               e.r = first_reg + (inc_reg ? 4'(i) : 4'd0);
               e.w = is_store;
               mq.push_back(e);
            end
         end
      end
   end

   // ---------------- per-cycle comparison against the model ------------------
   always @(negedge clk) begin : compare
      bit req_e, busy_e, wen_e;
      if (en_cmp) begin
         req_e  = (mq.size() != 0);
         busy_e = req_e || m_done;
         chk("mem_req", 32'(mem_req), 32'(req_e));
         chk("busy", 32'(busy), 32'(busy_e));
         chk("start_ready", 32'(start_ready), 32'(!busy_e));
         chk("done", 32'(done), 32'(m_done));
         wen_e = 1'b0;
         if (req_e) begin
            chk("mem_addr", 32'(mem_addr), 32'(mq[0].a));
            chk("rs_addr", 32'(rs_addr), 32'(mq[0].r));
            chk("rd_addr", 32'(rd_addr), 32'(mq[0].r));
            chk("mem_write", 32'(mem_write), 32'(mq[0].w));
            if (mq[0].w) chk("mem_wdata", mem_wdata, rs_data);
            wen_e = mem_ack && !mq[0].w && !rst;
         end
         chk("rd_wen", 32'(rd_wen), 32'(wen_e));
         if (wen_e) chk("rd_data", rd_data, mem_rdata);
      end
   end

   // ---------------- transaction log for literal expectations ----------------
   logic [27:0] log_addr[$];
   logic [3:0]  log_rs[$];
   logic [3:0]  log_wr[$];
   int done_cnt = 0, cyc = 0, last_ack_cyc = 0, done_cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (mem_req && mem_ack) begin
         log_addr.push_back(mem_addr);
         log_rs.push_back(rs_addr);
         last_ack_cyc = cyc;
      end
      if (rd_wen) log_wr.push_back(rd_addr);
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   // ---------------- memory responder ----------------------------------------
   int  ack_delay = 0;
   bit  ack_force = 1'b0;
   initial begin : responder
      int wait_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         mem_rdata = $urandom;
         rs_data   = $urandom;
         if (ack_force) mem_ack = 1'b1;
         else if (mem_req && !rst) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack  = 1'b1;
               wait_cnt = 0;
            end else begin
               mem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_rs.delete();
      log_wr.delete();
      done_cnt = 0;
   endtask

   task automatic do_start(input logic [27:0] b, input logic [3:0] r, input logic [2:0] n,
                           input logic st, input logic inc);
      base_addr = b; first_reg = r; num_extra = n; is_store = st; inc_reg = inc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 100) begin
         tick();
         k++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ------------------------------------------
   initial begin
      #1 rst = 1'b1;
      #3;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_start_ready", 32'(start_ready), 32'd1);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_rs_addr", 32'(rs_addr), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      tick();
      rst = 1'b0;
      en_cmp = 1'b1;
      tick();

      // Load x4, ack every cycle
      clear_log();
      ack_delay = 0;
      do_start(28'h100, 4'd8, 3'd3, 1'b0, 1'b1);
      wait_idle();
      chk("ld4_count", 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_addr.size(); i++)
         chk("ld4_addr", 32'(log_addr[i]), 32'h100 + 32'(4 * i));
      chk("ld4_wr_count", 32'(log_wr.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_wr.size(); i++)
         chk("ld4_rd_reg", 32'(log_wr[i]), 32'(8 + i));
      chk("ld4_done_cnt", 32'(done_cnt), 32'd1);
      chk("ld4_done_lat", 32'(done_cyc - last_ack_cyc), 32'd1);

      // Memset: store, no reg increment, 3-cycle ack stall
      clear_log();
      ack_delay = 3;
      do_start(28'h200, 4'd5, 3'd3, 1'b1, 1'b0);
      wait_idle();
      chk("ms_count", 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_rs.size(); i++) begin
         chk("ms_rs_addr", 32'(log_rs[i]), 32'd5);
         chk("ms_addr", 32'(log_addr[i]), 32'h200 + 32'(4 * i));
      end
      chk("ms_no_rd_wen", 32'(log_wr.size()), 32'd0);

      // Address and register wrap
      clear_log();
      ack_delay = 1;
      do_start(28'hFFFFFF8, 4'd15, 3'd2, 1'b0, 1'b1);
      wait_idle();
      chk("wrap_count", 32'(log_addr.size()), 32'd3);
      if (log_addr.size() == 3) begin
         chk("wrap_a0", 32'(log_addr[0]), 32'h0FFFFFF8);
         chk("wrap_a1", 32'(log_addr[1]), 32'h0FFFFFFC);
         chk("wrap_a2", 32'(log_addr[2]), 32'h00000000);
      end
      if (log_wr.size() == 3) begin
         chk("wrap_r0", 32'(log_wr[0]), 32'd15);
         chk("wrap_r1", 32'(log_wr[1]), 32'd0);
         chk("wrap_r2", 32'(log_wr[2]), 32'd1);
      end

      // Single access; start during DONE must be ignored
      clear_log();
      ack_delay = 0;
      do_start(28'h300, 4'd2, 3'd0, 1'b0, 1'b1);
      tick();
      chk("single_done", 32'(done), 32'd1);
      base_addr = 28'h500; first_reg = 4'd7; num_extra = 3'd1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("single_count", 32'(log_addr.size()), 32'd1);
      chk("single_done_cnt", 32'(done_cnt), 32'd1);

      // Flush together with the 2nd ack of a 4-op load
      clear_log();
      ack_delay = 0;
      do_start(28'h100, 4'd8, 3'd3, 1'b0, 1'b1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_start_ready", 32'(start_ready), 32'd1);
      chk("fl_mem_req", 32'(mem_req), 32'd0);
      repeat (3) tick();
      chk("fl_wr_count", 32'(log_wr.size()), 32'd2);
      if (log_wr.size() == 2) begin
         chk("fl_r0", 32'(log_wr[0]), 32'd8);
         chk("fl_r1", 32'(log_wr[1]), 32'd9);
      end
      chk("fl_no_done", 32'(done_cnt), 32'd0);

      // Flush in IDLE blocks start
      clear_log();
      flush = 1'b1;
      do_start(28'h600, 4'd1, 3'd1, 1'b0, 1'b1);
      flush = 1'b0;
      chk("fl_idle_block", 32'(busy), 32'd0);

      // Spurious ack while idle
      ack_force = 1'b1;
      repeat (2) tick();
      ack_force = 1'b0;
      tick();
      chk("spurious_wr", 32'(log_wr.size()), 32'd0);

      // Asynchronous reset mid-burst, then a new burst
      clear_log();
      ack_delay = 2;
      do_start(28'h40, 4'd3, 3'd3, 1'b1, 1'b1);
      repeat (4) tick();
      #2 rst = 1'b1;
      #1;
      chk("ar_mem_req", 32'(mem_req), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_start_ready", 32'(start_ready), 32'd1);
      chk("ar_mem_addr", 32'(mem_addr), 32'd0);
      chk("ar_rs_addr", 32'(rs_addr), 32'd0);
      chk("ar_rd_addr", 32'(rd_addr), 32'd0);
      chk("ar_mem_write", 32'(mem_write), 32'd0);
      chk("ar_done", 32'(done), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      clear_log();
      ack_delay = 0;
      do_start(28'h80, 4'd12, 3'd1, 1'b0, 1'b1);
      wait_idle();
      chk("ar_new_count", 32'(log_wr.size()), 32'd2);
      if (log_addr.size() == 2) begin
         chk("ar_new_a0", 32'(log_addr[0]), 32'h80);
         chk("ar_new_a1", 32'(log_addr[1]), 32'h84);
      end

      en_cmp = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
